// File: rtl/vending_pkg.sv
// Shared codes and state encoding for the vending FSM and dispenser.
// Includes the change-code to coin-count decode.
package vending_pkg;

  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_20   = 2'd1;
  localparam logic [1:0] ITEM_50   = 2'd2;

  localparam logic [1:0] CHG_NONE  = 2'd0;
  localparam logic [1:0] CHG_10    = 2'd1;
  localparam logic [1:0] CHG_30    = 2'd2;
  localparam logic [1:0] CHG_40    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_COIN,
    ST_GAP,
    ST_COMPLETE,
    ST_FAULT
  } disp_state_e;

  function automatic logic [3:0] coin_count(input logic [1:0] chg);
    logic [3:0] n;
    unique case (chg)
      CHG_10:  n = 4'd1;
      CHG_30:  n = 4'd3;
      CHG_40:  n = 4'd4;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter; expired_o is high while the count is zero.
// Shared by the motor pulse, coin gap and ack timeout.
module vend_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/vending_dispenser.sv
// Actuator stage: item motor pulse, then 10-dollar coins via req/ack.
// One pending slot absorbs a back-to-back vend.
module vending_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] item_i,
  input  logic [1:0] change_i,
  input  logic       coin_ack_i,
  output logic       motor_20_o,
  output logic       motor_50_o,
  output logic       coin_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overflow_o,
  output logic       fault_o
);

  localparam int TW = 8;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LD   = TW'(ACK_TIMEOUT - 1);

  disp_state_e state_q, state_d;
  logic [1:0]  item_q, item_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_item_q, pend_item_d;
  logic [3:0]  pend_cnt_q, pend_cnt_d;
  logic        ovf_q, ovf_d;

  logic          req;
  logic          direct;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_exp;

  assign req    = (item_i == ITEM_20) || (item_i == ITEM_50);
  assign direct = (state_q == ST_IDLE) && !pend_vld_q;

  vend_cycle_timer #(.W(TW)) u_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      item_q      <= ITEM_NONE;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_item_q <= ITEM_NONE;
      pend_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_item_q <= pend_item_d;
      pend_cnt_q  <= pend_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    item_d      = item_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_item_d = pend_item_q;
    pend_cnt_d  = pend_cnt_q;
    ovf_d       = ovf_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          item_d     = pend_item_q;
          cnt_d      = pend_cnt_q;
          pend_vld_d = 1'b0;
          state_d    = ST_MOTOR;
          tmr_load   = 1'b1;
          tmr_val    = PULSE_LD;
        end else if (req) begin
          item_d   = item_i;
          cnt_d    = coin_count(change_i);
          state_d  = ST_MOTOR;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_MOTOR, ST_GAP: begin
        if (!tmr_exp) begin
          tmr_en = 1'b1;
        end else if (cnt_q != '0) begin
          state_d  = ST_COIN;
          tmr_load = 1'b1;
          tmr_val  = ACK_LD;
        end else begin
          state_d = ST_COMPLETE;
        end
      end
      ST_COIN: begin
        if (coin_ack_i) begin
          cnt_d    = cnt_q - 4'd1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else if (tmr_exp) begin
          state_d = ST_FAULT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_COMPLETE: state_d = ST_IDLE;
      ST_FAULT:    state_d = ST_FAULT;
      default:     state_d = ST_IDLE;
    endcase

    // Slot is free if empty or being consumed by IDLE this cycle.
    if (req && !direct) begin
      if (!pend_vld_q || (state_q == ST_IDLE)) begin
        pend_vld_d  = 1'b1;
        pend_item_d = item_i;
        pend_cnt_d  = coin_count(change_i);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign motor_20_o = (state_q == ST_MOTOR) && (item_q == ITEM_20);
  assign motor_50_o = (state_q == ST_MOTOR) && (item_q == ITEM_50);
  assign coin_req_o = (state_q == ST_COIN);
  assign busy_o     = (state_q != ST_IDLE) || pend_vld_q;
  assign done_o     = (state_q == ST_COMPLETE);
  assign overflow_o = ovf_q;
  assign fault_o    = (state_q == ST_FAULT);

endmodule
